inst_cache: RTL

Direct-mapped instruction cache that answers PC fetch requests from the fetch stage and returns instruction words. On a hit it returns the word with 1-cycle latency. On a miss it stalls the fetch stage and refills a full line from the instruction-memory interface using an in-order burst. It sits between the fetch unit's PC output (stall/PC handshake) and external instruction memory.

---
 rtl/inst_cache.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache: hits return a word one cycle after the request; a miss stalls fetch
// combinationally and refills the whole line by in-order burst. Optional hit/miss counters under ICACHE_STATS_EN.
module inst_cache #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int INDEX_BITS    = 6,
  parameter int OFFSET_BITS   = 2
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset_n,
  input  logic                     i_Read,
  input  logic [ADDRESS_WIDTH-1:0] i_Address,
  input  logic                     i_Flush,
  output logic [DATA_WIDTH-1:0]    o_Instruction,
  output logic                     o_Valid,
  output logic                     o_Stall,
  output logic                     o_Mem_Read,
  output logic [ADDRESS_WIDTH-1:0] o_Mem_Address,
  input  logic [DATA_WIDTH-1:0]    i_Mem_Data,
  input  logic                     i_Mem_Valid
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]              o_Hit_Count,
  output logic [31:0]              o_Miss_Count
`endif
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;
  localparam int TAG_BITS = ADDRESS_WIDTH - INDEX_BITS - OFFSET_BITS;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                   state_q, state_d;
  logic [LINES-1:0]         valid_q, valid_d;
  logic [TAG_BITS-1:0]      tag_q  [LINES];
  logic [DATA_WIDTH-1:0]    data_q [LINES*WORDS];
  logic [OFFSET_BITS-1:0]   cnt_q, cnt_d;
  logic                     vld_q, vld_d;
  logic [DATA_WIDTH-1:0]    inst_q, inst_d;
  logic                     mem_rd_q, mem_rd_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;

  logic [OFFSET_BITS-1:0]   req_off;
  logic [INDEX_BITS-1:0]    req_idx;
  logic [TAG_BITS-1:0]      req_tag;
  logic [INDEX_BITS-1:0]    fill_idx;
  logic [TAG_BITS-1:0]      fill_tag;
  logic                     hit;
  logic                     lookup_hit;
  logic                     lookup_miss;
  logic                     word_wr;
  logic                     fill_done;

  assign req_off  = i_Address[OFFSET_BITS-1:0];
  assign req_idx  = i_Address[OFFSET_BITS +: INDEX_BITS];
  assign req_tag  = i_Address[ADDRESS_WIDTH-1 -: TAG_BITS];
  assign fill_idx = mem_addr_q[OFFSET_BITS +: INDEX_BITS];
  assign fill_tag = mem_addr_q[ADDRESS_WIDTH-1 -: TAG_BITS];

  // A same-cycle flush demotes a would-be hit to a miss.
  assign hit = i_Read & valid_q[req_idx] & (tag_q[req_idx] == req_tag) & ~i_Flush;

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_Read && !hit) state_d = FILL;
      FILL:    if (fill_done)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lookup_hit  = (state_q == IDLE) & hit;
    lookup_miss = (state_q == IDLE) & i_Read & ~hit;
    word_wr     = (state_q == FILL) & i_Mem_Valid;
    fill_done   = word_wr & (cnt_q == OFFSET_BITS'(WORDS - 1));
    o_Stall     = (state_q == FILL) | lookup_miss;
  end

  always_comb begin
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    vld_d      = lookup_hit;
    inst_d     = inst_q;
    mem_rd_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
    if (i_Flush) valid_d = '0;
    // An in-flight fill still validates its line even after a flush.
    if (fill_done) begin
      valid_d[fill_idx] = 1'b1;
      mem_rd_d          = 1'b0;
    end
    if (lookup_hit) inst_d = data_q[{req_idx, req_off}];
    if (lookup_miss) begin
      mem_addr_d = {req_tag, req_idx, {OFFSET_BITS{1'b0}}};
      mem_rd_d   = 1'b1;
      cnt_d      = '0;
    end
    if (word_wr) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      valid_q    <= '0;
      cnt_q      <= '0;
      vld_q      <= 1'b0;
      inst_q     <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      vld_q      <= vld_d;
      inst_q     <= inst_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (word_wr)   data_q[{fill_idx, cnt_q}] <= i_Mem_Data;
    if (fill_done) tag_q[fill_idx]           <= fill_tag;
  end

  assign o_Instruction = inst_q;
  assign o_Valid       = vld_q;
  assign o_Mem_Read    = mem_rd_q;
  assign o_Mem_Address = mem_addr_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (lookup_hit  && hit_cnt_q  != 32'hFFFF_FFFF) hit_cnt_d  = hit_cnt_q + 32'd1;
    if (lookup_miss && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign o_Hit_Count  = hit_cnt_q;
  assign o_Miss_Count = miss_cnt_q;
`endif

endmodule
